spec_phase_sched: RTL and testbench

- Frame-level scheduler for the power-spectrum accumulation datapath.
- Sequences one measurement frame through its phases: pulse capture/accumulate over N pulses, background deduction pass, peak detection pass.
- Arbitrates the single read port of the 16x1024 spectrum DPRAM among three requesters: accumulator, peak detector and host readout.
- Replaces ad-hoc enable generation; sits between the user-register interface and the accumulation, background and peak-detection controllers.

---
 rtl/spec_phase_sched.sv | 171 +++++++++++++++++
 tb/tb_spec_phase_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spec_phase_sched.sv
// Frame phase scheduler: sequences ACC -> DRAIN -> BG -> PD -> DONE and arbitrates the DPRAM read port.
// Optional BG/PD watchdog enabled by defining SPEC_SCHED_WATCHDOG_EN.
module spec_phase_sched #(
   parameter int PCNT_W      = 16,
   parameter int ADDR_W      = 14,
   parameter int WDOG_CYCLES = 65535
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [PCNT_W-1:0] pulse_target_i,
   input  logic              spec_acc_done_i,
   input  logic              bg_done_i,
   input  logic              pd_done_i,
   input  logic [ADDR_W-1:0] acc_rdaddr_i,
   input  logic [ADDR_W-1:0] pd_rdaddr_i,
   input  logic [ADDR_W-1:0] host_rdaddr_i,
   input  logic              host_rd_req_i,
   output logic              host_rd_gnt_o,
   output logic [ADDR_W-1:0] ram_rdaddr_o,
   output logic              capture_en_o,
   output logic              acc_ctrl_o,
   output logic              bg_en_o,
   output logic              pd_en_o,
   output logic [PCNT_W-1:0] pulse_count_o,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic              err_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_ACC, S_DRAIN, S_BG, S_PD, S_DONE
   } state_t;

   state_t            state_q;
   logic [PCNT_W-1:0] target_q;
   logic [1:0]        drain_cnt_q;
   logic [PCNT_W-1:0] count_inc;

`ifdef SPEC_SCHED_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   logic [WDOG_W-1:0] wdog_cnt_q;
   logic              wdog_hit;
   assign wdog_hit = (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
`endif

   assign count_inc = pulse_count_o + 1'b1;

   // PD owns the port outright; the host can only hold a grant while IDLE.
   always_comb begin
      ram_rdaddr_o = acc_rdaddr_i;
      if (state_q == S_PD)
         ram_rdaddr_o = pd_rdaddr_i;
      else if (host_rd_gnt_o)
         ram_rdaddr_o = host_rdaddr_i;
   end

   // NOTE: every register here is updated with <= so all branches see the pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         target_q      <= '0;
         drain_cnt_q   <= '0;
         host_rd_gnt_o <= 1'b0;
         capture_en_o  <= 1'b0;
         acc_ctrl_o    <= 1'b0;
         bg_en_o       <= 1'b0;
         pd_en_o       <= 1'b0;
         pulse_count_o <= '0;
         busy_o        <= 1'b0;
         frame_done_o  <= 1'b0;
         err_o         <= 1'b0;
`ifdef SPEC_SCHED_WATCHDOG_EN
         wdog_cnt_q    <= '0;
`endif
      end else begin
         // NOTE: defaulting the strobe here makes frame_done_o a single-cycle pulse.
         frame_done_o  <= 1'b0;
         host_rd_gnt_o <= host_rd_req_i && (state_q == S_IDLE);
`ifdef SPEC_SCHED_WATCHDOG_EN
         wdog_cnt_q    <= wdog_cnt_q + 1'b1;
`endif
         if (abort_i) begin
            state_q      <= S_IDLE;
            capture_en_o <= 1'b0;
            acc_ctrl_o   <= 1'b0;
            bg_en_o      <= 1'b0;
            pd_en_o      <= 1'b0;
            busy_o       <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  // A pending or granted host read blocks the start without flagging it.
                  if (start_i && !host_rd_gnt_o && !host_rd_req_i) begin
                     if (pulse_target_i == '0) begin
                        err_o <= 1'b1;
                     end else begin
                        state_q       <= S_ACC;
                        target_q      <= pulse_target_i;
                        pulse_count_o <= '0;
                        err_o         <= 1'b0;
                        capture_en_o  <= 1'b1;
                        acc_ctrl_o    <= 1'b0;
                        busy_o        <= 1'b1;
                     end
                  end
               end
               S_ACC: begin
                  if (spec_acc_done_i) begin
                     pulse_count_o <= count_inc;
                     acc_ctrl_o    <= 1'b1;
                     if (count_inc == target_q) begin
                        state_q      <= S_DRAIN;
                        drain_cnt_q  <= '0;
                        capture_en_o <= 1'b0;
                        acc_ctrl_o   <= 1'b0;
                     end
                  end
               end
               S_DRAIN: begin
                  if (drain_cnt_q == 2'd3) begin
                     state_q <= S_BG;
                     bg_en_o <= 1'b1;
`ifdef SPEC_SCHED_WATCHDOG_EN
                     wdog_cnt_q <= '0;
`endif
                  end else begin
                     drain_cnt_q <= drain_cnt_q + 1'b1;
                  end
               end
               S_BG: begin
                  if (bg_done_i) begin
                     state_q <= S_PD;
                     bg_en_o <= 1'b0;
                     pd_en_o <= 1'b1;
`ifdef SPEC_SCHED_WATCHDOG_EN
                     wdog_cnt_q <= '0;
                  end else if (wdog_hit) begin
                     state_q <= S_IDLE;
                     bg_en_o <= 1'b0;
                     busy_o  <= 1'b0;
                     err_o   <= 1'b1;
`endif
                  end
               end
               S_PD: begin
                  if (pd_done_i) begin
                     state_q      <= S_DONE;
                     pd_en_o      <= 1'b0;
                     frame_done_o <= 1'b1;
`ifdef SPEC_SCHED_WATCHDOG_EN
                  end else if (wdog_hit) begin
                     state_q <= S_IDLE;
                     pd_en_o <= 1'b0;
                     busy_o  <= 1'b0;
                     err_o   <= 1'b1;
`endif
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_o  <= 1'b0;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spec_phase_sched.sv
// Self-checking bench for spec_phase_sched: per-frame event timelines predicted from the phase rules.
// Watchdog scenario runs when SPEC_SCHED_WATCHDOG_EN is defined; otherwise checks that BG waits indefinitely.
module tb_spec_phase_sched;
   localparam int PCNT_W = 16;
   localparam int ADDR_W = 14;
   localparam int WDOG   = 100;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              start_i, abort_i;
   logic [PCNT_W-1:0] pulse_target_i;
   logic              spec_acc_done_i, bg_done_i, pd_done_i;
   logic [ADDR_W-1:0] acc_rdaddr_i, pd_rdaddr_i, host_rdaddr_i;
   logic              host_rd_req_i, host_rd_gnt_o;
   logic [ADDR_W-1:0] ram_rdaddr_o;
   logic              capture_en_o, acc_ctrl_o, bg_en_o, pd_en_o;
   logic [PCNT_W-1:0] pulse_count_o;
   logic              busy_o, frame_done_o, err_o;

   int checks = 0;
   int errors = 0;
   bit exp_err = 1'b0;

   always #5 clk_i = ~clk_i;

   spec_phase_sched #(.PCNT_W(PCNT_W), .ADDR_W(ADDR_W), .WDOG_CYCLES(WDOG)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .pulse_target_i(pulse_target_i), .spec_acc_done_i(spec_acc_done_i),
      .bg_done_i(bg_done_i), .pd_done_i(pd_done_i),
      .acc_rdaddr_i(acc_rdaddr_i), .pd_rdaddr_i(pd_rdaddr_i), .host_rdaddr_i(host_rdaddr_i),
      .host_rd_req_i(host_rd_req_i), .host_rd_gnt_o(host_rd_gnt_o), .ram_rdaddr_o(ram_rdaddr_o),
      .capture_en_o(capture_en_o), .acc_ctrl_o(acc_ctrl_o), .bg_en_o(bg_en_o), .pd_en_o(pd_en_o),
      .pulse_count_o(pulse_count_o), .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
   );

   function automatic int n_before(input int q[$], input int k);
      int n = 0;
      foreach (q[i]) if (q[i] < k) n++;
      return n;
   endfunction

   function automatic bit is_in(input int q[$], input int k);
      foreach (q[i]) if (q[i] == k) return 1'b1;
      return 1'b0;
   endfunction

   task automatic quiet_inputs();
      start_i = 0; abort_i = 0; spec_acc_done_i = 0; bg_done_i = 0; pd_done_i = 0;
      host_rd_req_i = 0; pulse_target_i = '0;
      acc_rdaddr_i = ADDR_W'($urandom); pd_rdaddr_i = ADDR_W'($urandom);
      host_rdaddr_i = ADDR_W'($urandom);
   endtask

   task automatic step();
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      quiet_inputs();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
      checks++; if ({capture_en_o, acc_ctrl_o, bg_en_o, pd_en_o} !== 4'b0) begin errors++; $display("FAIL reset_enables got %b exp 0000", {capture_en_o, acc_ctrl_o, bg_en_o, pd_en_o}); end
      checks++; if (pulse_count_o !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", pulse_count_o); end
      checks++; if ({frame_done_o, err_o, host_rd_gnt_o} !== 3'b0) begin errors++; $display("FAIL reset_flags got %b exp 000", {frame_done_o, err_o, host_rd_gnt_o}); end
      checks++; if (ram_rdaddr_o !== acc_rdaddr_i) begin errors++; $display("FAIL reset_addr got %h exp %h", ram_rdaddr_o, acc_rdaddr_i); end
      rst_i = 1'b0;
      step();
   endtask

   // Runs one frame; every output is predicted per cycle from the event timeline of the frame.
   task automatic run_frame(input int t, input int bg_dly, input int pd_dly, input bit stray, input bit hold_req);
      int d[$];
      int c, dt, bg_on, b, p, last, e_cnt;
      bit e_cap, e_bg, e_pd, e_fd, e_busy, e_actl, e_gnt, e_errv;
      logic [ADDR_W-1:0] e_addr;
      c = 1 + $urandom_range(0, 2);
      for (int j = 0; j < t; j++) begin
         d.push_back(c);
         c += 1 + $urandom_range(0, 3);
      end
      dt    = d[t-1];
      bg_on = dt + 5;
      b     = bg_on + bg_dly;
      p     = b + 1 + pd_dly;
      last  = hold_req ? p + 4 : p + 2;
      for (int k = 0; k <= last; k++) begin
         quiet_inputs();
         start_i         = (k == 0);
         pulse_target_i  = (k == 0) ? PCNT_W'(t) : PCNT_W'($urandom_range(0, 9));
         spec_acc_done_i = is_in(d, k) || (stray && k > dt && k <= p + 1 && $urandom_range(0, 3) == 0);
         bg_done_i       = (k == b) || (stray && (k < bg_on || (k > b && k <= p + 1)) && $urandom_range(0, 3) == 0);
         pd_done_i       = (k == p) || (stray && k <= b && $urandom_range(0, 3) == 0);
         host_rd_req_i   = hold_req ? (k >= 1) : (k >= 1 && k <= p && $urandom_range(0, 2) == 0);
         if (stray && k >= 1 && k <= p + 1 && $urandom_range(0, 4) == 0) start_i = 1'b1;
         if (hold_req && k == p + 3) begin
            start_i = 1'b1;
            pulse_target_i = PCNT_W'(3);
         end
         @(negedge clk_i);
         e_cap  = (k >= 1 && k <= dt);
         e_bg   = (k >= bg_on && k <= b);
         e_pd   = (k >= b + 1 && k <= p);
         e_fd   = (k == p + 1);
         e_busy = (k >= 1 && k <= p + 1);
         e_cnt  = n_before(d, k);
         e_actl = e_cap && (e_cnt != 0);
         e_gnt  = hold_req && (k >= p + 3);
         e_errv = (k == 0) ? exp_err : 1'b0;
         e_addr = e_pd ? pd_rdaddr_i : (e_gnt ? host_rdaddr_i : acc_rdaddr_i);
         checks++; if (capture_en_o !== e_cap) begin errors++; $display("FAIL frame_capture k=%0d got %b exp %b", k, capture_en_o, e_cap); end
         checks++; if (acc_ctrl_o !== e_actl) begin errors++; $display("FAIL frame_acc_ctrl k=%0d got %b exp %b", k, acc_ctrl_o, e_actl); end
         checks++; if (bg_en_o !== e_bg) begin errors++; $display("FAIL frame_bg_en k=%0d got %b exp %b", k, bg_en_o, e_bg); end
         checks++; if (pd_en_o !== e_pd) begin errors++; $display("FAIL frame_pd_en k=%0d got %b exp %b", k, pd_en_o, e_pd); end
         checks++; if (frame_done_o !== e_fd) begin errors++; $display("FAIL frame_done k=%0d got %b exp %b", k, frame_done_o, e_fd); end
         checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL frame_busy k=%0d got %b exp %b", k, busy_o, e_busy); end
         checks++; if (err_o !== e_errv) begin errors++; $display("FAIL frame_err k=%0d got %b exp %b", k, err_o, e_errv); end
         checks++; if (host_rd_gnt_o !== e_gnt) begin errors++; $display("FAIL frame_gnt k=%0d got %b exp %b", k, host_rd_gnt_o, e_gnt); end
         checks++; if (ram_rdaddr_o !== e_addr) begin errors++; $display("FAIL frame_addr k=%0d got %h exp %h", k, ram_rdaddr_o, e_addr); end
         if (k >= 1) begin
            checks++; if (pulse_count_o !== PCNT_W'(e_cnt)) begin errors++; $display("FAIL frame_count k=%0d got %0d exp %0d", k, pulse_count_o, e_cnt); end
         end
         step();
      end
      exp_err = 1'b0;
      quiet_inputs();
      host_rd_req_i = hold_req;
   endtask

   task automatic test_basic_frame();
      run_frame(3, 10, 20, 1'b0, 1'b0);
   endtask

   task automatic test_zero_target();
      quiet_inputs();
      start_i = 1'b1;
      step();
      quiet_inputs();
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy_o); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL zero_err got %b exp 1", err_o); end
      checks++; if ({capture_en_o, bg_en_o, pd_en_o} !== 3'b0) begin errors++; $display("FAIL zero_enables got %b exp 000", {capture_en_o, bg_en_o, pd_en_o}); end
      exp_err = 1'b1;
      step();
      run_frame(2, 2, 2, 1'b0, 1'b0);
   endtask

   task automatic test_random_frames();
      for (int n = 0; n < 8; n++)
         run_frame($urandom_range(1, 6), $urandom_range(0, 5), $urandom_range(0, 5), 1'b1, 1'b0);
   endtask

   task automatic test_host();
      // Same-cycle request and start: the grant wins.
      quiet_inputs();
      host_rd_req_i = 1'b1; start_i = 1'b1; pulse_target_i = PCNT_W'(3);
      step();
      start_i = 1'b0;
      @(negedge clk_i);
      checks++; if (host_rd_gnt_o !== 1'b1) begin errors++; $display("FAIL host_gnt got %b exp 1", host_rd_gnt_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL host_start_blocked got %b exp 0", busy_o); end
      checks++; if (ram_rdaddr_o !== host_rdaddr_i) begin errors++; $display("FAIL host_addr got %h exp %h", ram_rdaddr_o, host_rdaddr_i); end
      step();
      host_rd_req_i = 1'b0;
      @(negedge clk_i);
      checks++; if (host_rd_gnt_o !== 1'b1) begin errors++; $display("FAIL host_release_latency got %b exp 1", host_rd_gnt_o); end
      step();
      @(negedge clk_i);
      checks++; if (host_rd_gnt_o !== 1'b0) begin errors++; $display("FAIL host_released got %b exp 0", host_rd_gnt_o); end
      checks++; if (ram_rdaddr_o !== acc_rdaddr_i) begin errors++; $display("FAIL host_addr_back got %h exp %h", ram_rdaddr_o, acc_rdaddr_i); end
      step();
      // Request held through a whole frame: granted only once back in IDLE.
      run_frame(4, 3, 3, 1'b0, 1'b1);
      host_rd_req_i = 1'b0;
      @(negedge clk_i);
      checks++; if (host_rd_gnt_o !== 1'b1) begin errors++; $display("FAIL host_hold_gnt got %b exp 1", host_rd_gnt_o); end
      step();
      @(negedge clk_i);
      checks++; if (host_rd_gnt_o !== 1'b0) begin errors++; $display("FAIL host_hold_release got %b exp 0", host_rd_gnt_o); end
      step();
   endtask

   task automatic test_abort();
      bit fd_seen = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         quiet_inputs();
         start_i = (k == 0);
         pulse_target_i = PCNT_W'(5);
         spec_acc_done_i = (k == 2 || k == 4);
         abort_i = (k == 4);
         @(negedge clk_i);
         if (k == 3) begin
            checks++; if (pulse_count_o !== PCNT_W'(1)) begin errors++; $display("FAIL abort_mid_count got %0d exp 1", pulse_count_o); end
            checks++; if (acc_ctrl_o !== 1'b1) begin errors++; $display("FAIL abort_mid_acc_ctrl got %b exp 1", acc_ctrl_o); end
         end
         if (k == 5) begin
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy_o); end
            checks++; if (pulse_count_o !== PCNT_W'(1)) begin errors++; $display("FAIL abort_count got %0d exp 1", pulse_count_o); end
            checks++; if ({capture_en_o, acc_ctrl_o, bg_en_o, pd_en_o} !== 4'b0) begin errors++; $display("FAIL abort_enables got %b exp 0000", {capture_en_o, acc_ctrl_o, bg_en_o, pd_en_o}); end
         end
         step();
      end
      quiet_inputs();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_i);
         if (frame_done_o) fd_seen = 1'b1;
         step();
      end
      checks++; if (fd_seen !== 1'b0) begin errors++; $display("FAIL abort_frame_done got %b exp 0", fd_seen); end
      // Abort beats a same-cycle start.
      start_i = 1'b1; abort_i = 1'b1; pulse_target_i = PCNT_W'(2);
      step();
      quiet_inputs();
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_vs_start got %b exp 0", busy_o); end
      step();
   endtask

   task automatic test_reset_mid_frame();
      quiet_inputs();
      start_i = 1'b1; pulse_target_i = PCNT_W'(4);
      step();
      quiet_inputs();
      spec_acc_done_i = 1'b1;
      step();
      quiet_inputs();
      #2 rst_i = 1'b1;
      #1;
      checks++; if ({busy_o, capture_en_o, acc_ctrl_o} !== 3'b0) begin errors++; $display("FAIL rst_mid_outputs got %b exp 000", {busy_o, capture_en_o, acc_ctrl_o}); end
      checks++; if (pulse_count_o !== '0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", pulse_count_o); end
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_err = 1'b0;
      step();
   endtask

   task automatic test_watchdog();
      bit e_bg, e_busy, e_errv;
      bit pd_seen = 1'b0;
      int last;
`ifdef SPEC_SCHED_WATCHDOG_EN
      last = 6 + WDOG + 3;
`else
      last = 6 + 2 * WDOG;
`endif
      for (int k = 0; k <= last; k++) begin
         quiet_inputs();
         start_i = (k == 0);
         pulse_target_i = PCNT_W'(1);
         spec_acc_done_i = (k == 1);
         @(negedge clk_i);
`ifdef SPEC_SCHED_WATCHDOG_EN
         e_bg   = (k >= 6 && k < 6 + WDOG);
         e_busy = (k >= 1 && k < 6 + WDOG);
         e_errv = (k >= 6 + WDOG);
`else
         e_bg   = (k >= 6);
         e_busy = (k >= 1);
         e_errv = 1'b0;
`endif
         if (pd_en_o) pd_seen = 1'b1;
         checks++; if (bg_en_o !== e_bg) begin errors++; $display("FAIL wdog_bg_en k=%0d got %b exp %b", k, bg_en_o, e_bg); end
         checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL wdog_busy k=%0d got %b exp %b", k, busy_o, e_busy); end
         checks++; if (err_o !== e_errv) begin errors++; $display("FAIL wdog_err k=%0d got %b exp %b", k, err_o, e_errv); end
         step();
      end
      checks++; if (pd_seen !== 1'b0) begin errors++; $display("FAIL wdog_pd_en got %b exp 0", pd_seen); end
      quiet_inputs();
      abort_i = 1'b1;
      step();
      quiet_inputs();
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wdog_final_idle got %b exp 0", busy_o); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_zero_target();
      test_random_frames();
      test_host();
      test_abort();
      test_reset_mid_frame();
      test_watchdog();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
